// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcodes, field positions, fetch FSM states.
package mips_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned OPC_W = 6;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'd0;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'd4;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'd5;
  localparam logic [OPC_W-1:0] OP_SW    = 6'd43;
  localparam logic [OPC_W-1:0] OP_LW    = 6'd35;

  // sll $0,$0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned RS_MSB  = 25;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_MSB  = 20;
  localparam int unsigned RT_LSB  = 16;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    RUN      = 2'd1,
    STALL    = 2'd2,
    REDIRECT = 2'd3
  } fsm_state_e;

  // IF/ID pipeline register payload
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic            valid;
  } ifid_reg_t;

  // Opcodes whose rt field is a source operand
  function automatic logic uses_rt(input logic [OPC_W-1:0] opc);
    return (opc == OP_RTYPE) || (opc == OP_BEQ) || (opc == OP_BNE) || (opc == OP_SW);
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch-stage bus: instruction memory, redirect/hazard inputs and IF/ID outputs.
interface if_id_stage_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic [31:0]      imem_addr;
  logic [31:0]      imem_rdata;
  logic             mem_wait;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic [31:0]      currentPC_out;
  logic [31:0]      nextPC_out;
  logic [31:0]      instr_out;
  logic             valid_out;
  logic             id_ex_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Fetch stage side
  modport master (
    output imem_addr, currentPC_out, nextPC_out, instr_out, valid_out,
           id_ex_bubble, stall_cnt, flush_cnt,
    input  imem_rdata, mem_wait, branch_taken, branch_target, ex_mem_read, ex_rt
  );

  // Memory / downstream pipeline side
  modport slave (
    input  imem_addr, currentPC_out, nextPC_out, instr_out, valid_out,
           id_ex_bubble, stall_cnt, flush_cnt,
    output imem_rdata, mem_wait, branch_taken, branch_target, ex_mem_read, ex_rt
  );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard: a load in EX writes a register the IF/ID instruction reads.
module load_use_detect (
  input  logic       valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [5:0] opcode,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic       hazard_c
);

  import mips_pkg::*;

  // Register $0 is never a true dependency
  always_comb begin
    hazard_c = valid & ex_mem_read & (ex_rt != 5'd0) &
               ((ex_rt == rs) | (uses_rt(opcode) & (ex_rt == rt)));
  end

endmodule

// File: rtl/if_id_stage.sv
// Fetch front end: PC register, IF/ID register, load-use stall and branch flush.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  if_id_stage_if.master bus
);

  import mips_pkg::*;

  logic [XLEN-1:0]  pc_q, pc_d;
  ifid_reg_t        ifid_q, ifid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  fsm_state_e       state_q, state_d;
  logic             hazard_c;

  load_use_detect u_load_use_detect (
    .valid       (ifid_q.valid),
    .ex_mem_read (bus.ex_mem_read),
    .ex_rt       (bus.ex_rt),
    .opcode      (ifid_q.instr[OPC_MSB:OPC_LSB]),
    .rs          (ifid_q.instr[RS_MSB:RS_LSB]),
    .rt          (ifid_q.instr[RT_MSB:RT_LSB]),
    .hazard_c    (hazard_c)
  );

  // State register: PC, IF/ID, counters, FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q           <= RESET_PC;
      ifid_q.instr   <= NOP_INSTR;
      ifid_q.pc      <= 32'd0;
      ifid_q.next_pc <= 32'd0;
      ifid_q.valid   <= 1'b0;
      stall_q        <= '0;
      flush_q        <= '0;
      state_q        <= FILL;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      state_q <= state_d;
    end
  end

  // Next-state: freeze > redirect > load-use stall > sequential fetch
  always_comb begin
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    stall_d = stall_q;
    flush_d = flush_q;
    state_d = state_q;
    if (bus.mem_wait) begin
      state_d = state_q;
    end else if (bus.branch_taken) begin
      pc_d         = bus.branch_target & ~32'h0000_0003;
      ifid_d.instr = NOP_INSTR;
      ifid_d.valid = 1'b0;
      flush_d      = (flush_q == '1) ? flush_q : flush_q + CNT_W'(1);
      state_d      = REDIRECT;
    end else if (hazard_c) begin
      stall_d = (stall_q == '1) ? stall_q : stall_q + CNT_W'(1);
      state_d = STALL;
    end else begin
      ifid_d.instr   = bus.imem_rdata;
      ifid_d.pc      = pc_q;
      ifid_d.next_pc = pc_q + 32'd4;
      ifid_d.valid   = 1'b1;
      pc_d           = pc_q + 32'd4;
      state_d        = RUN;
    end
  end

  // Output drive; id_ex_bubble is the only combinational output
  assign bus.imem_addr     = pc_q;
  assign bus.currentPC_out = ifid_q.pc;
  assign bus.nextPC_out    = ifid_q.next_pc;
  assign bus.instr_out     = ifid_q.instr;
  assign bus.valid_out     = ifid_q.valid;
  assign bus.stall_cnt     = stall_q;
  assign bus.flush_cnt     = flush_q;
  assign bus.id_ex_bubble  = bus.mem_wait | hazard_c | ~ifid_q.valid | bus.branch_taken;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for the fetch front end.
module tb_if_id_stage;

  localparam int unsigned CNT_W = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem [64];
  int          checks;
  int          errors;

  logic [31:0] add_hz;
  logic [31:0] add_r0;
  logic [31:0] sw_rt5;
  logic [31:0] addi_rt5;

  if_id_stage_if #(.CNT_W(CNT_W)) bus ();

  if_id_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000),
    .CNT_W     (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.imem_rdata = mem[bus.imem_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", bus.imem_addr, 32'h0); end
    checks++; if (bus.instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected %h", bus.instr_out, 32'h0); end
    checks++; if (bus.currentPC_out !== 32'h0 || bus.nextPC_out !== 32'h0) begin errors++; $display("FAIL reset_pcs: got %h/%h expected 0/0", bus.currentPC_out, bus.nextPC_out); end
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid_out); end
    checks++; if (bus.id_ex_bubble !== 1'b1) begin errors++; $display("FAIL reset_bubble: got %b expected 1", bus.id_ex_bubble); end
    checks++; if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", bus.stall_cnt, bus.flush_cnt); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL fill_valid: got %b expected 0", bus.valid_out); end
  endtask

  task automatic test_fetch();
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (bus.instr_out !== mem[k]) begin errors++; $display("FAIL fetch_instr[%0d]: got %h expected %h", k, bus.instr_out, mem[k]); end
      checks++; if (bus.currentPC_out !== 32'(4*k) || bus.nextPC_out !== 32'(4*k+4)) begin errors++; $display("FAIL fetch_pcs[%0d]: got %h/%h expected %h/%h", k, bus.currentPC_out, bus.nextPC_out, 32'(4*k), 32'(4*k+4)); end
      checks++; if (bus.valid_out !== 1'b1 || bus.id_ex_bubble !== 1'b0) begin errors++; $display("FAIL fetch_valid[%0d]: got v=%b b=%b expected v=1 b=0", k, bus.valid_out, bus.id_ex_bubble); end
      checks++; if (bus.imem_addr !== 32'(4*k+4)) begin errors++; $display("FAIL fetch_pc[%0d]: got %h expected %h", k, bus.imem_addr, 32'(4*k+4)); end
    end
  endtask

  task automatic test_load_use();
    step();  // IF/ID = add $3,$5,$2 at 0x10
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd5;
    #1;
    checks++; if (bus.id_ex_bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble: got %b expected 1", bus.id_ex_bubble); end
    step();
    checks++; if (bus.imem_addr !== 32'h14 || bus.currentPC_out !== 32'h10 || bus.instr_out !== add_hz) begin errors++; $display("FAIL lu_hold: got pc=%h cur=%h ins=%h expected 14/10/%h", bus.imem_addr, bus.currentPC_out, bus.instr_out, add_hz); end
    checks++; if (bus.stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d expected 1", bus.stall_cnt); end
    bus.ex_mem_read = 1'b0;
    #1;
    checks++; if (bus.id_ex_bubble !== 1'b0) begin errors++; $display("FAIL lu_release: got %b expected 0", bus.id_ex_bubble); end
    step();  // IF/ID = add $3,$0,$0 at 0x14
    checks++; if (bus.instr_out !== add_r0 || bus.imem_addr !== 32'h18) begin errors++; $display("FAIL lu_resume: got ins=%h pc=%h expected %h/18", bus.instr_out, bus.imem_addr, add_r0); end
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd0;
    #1;
    checks++; if (bus.id_ex_bubble !== 1'b0) begin errors++; $display("FAIL lu_r0: got %b expected 0", bus.id_ex_bubble); end
    step();  // IF/ID = sw $5 at 0x18
    checks++; if (bus.stall_cnt !== 4'd1 || bus.instr_out !== sw_rt5) begin errors++; $display("FAIL lu_r0_adv: got cnt=%0d ins=%h expected 1/%h", bus.stall_cnt, bus.instr_out, sw_rt5); end
    bus.ex_rt = 5'd5;
    #1;
    checks++; if (bus.id_ex_bubble !== 1'b1) begin errors++; $display("FAIL sw_rt_bubble: got %b expected 1", bus.id_ex_bubble); end
    step();
    checks++; if (bus.stall_cnt !== 4'd2 || bus.imem_addr !== 32'h1C) begin errors++; $display("FAIL sw_rt_stall: got cnt=%0d pc=%h expected 2/1c", bus.stall_cnt, bus.imem_addr); end
    bus.ex_mem_read = 1'b0;
    step();  // IF/ID = addi $5,$1,1 at 0x1C
    bus.ex_mem_read = 1'b1;
    #1;
    checks++; if (bus.id_ex_bubble !== 1'b0 || bus.instr_out !== addi_rt5) begin errors++; $display("FAIL addi_rt: got b=%b ins=%h expected 0/%h", bus.id_ex_bubble, bus.instr_out, addi_rt5); end
    step();  // IF/ID = add $3,$5,$2 at 0x20
    checks++; if (bus.stall_cnt !== 4'd2 || bus.imem_addr !== 32'h24) begin errors++; $display("FAIL addi_nostall: got cnt=%0d pc=%h expected 2/24", bus.stall_cnt, bus.imem_addr); end
  endtask

  task automatic test_branch_flush();
    bus.branch_taken = 1'b1; bus.branch_target = 32'h41;
    #1;
    checks++; if (bus.id_ex_bubble !== 1'b1) begin errors++; $display("FAIL br_bubble: got %b expected 1", bus.id_ex_bubble); end
    step();
    checks++; if (bus.imem_addr !== 32'h40) begin errors++; $display("FAIL br_pc: got %h expected %h", bus.imem_addr, 32'h40); end
    checks++; if (bus.instr_out !== 32'h0 || bus.valid_out !== 1'b0) begin errors++; $display("FAIL br_flush: got ins=%h v=%b expected 0/0", bus.instr_out, bus.valid_out); end
    checks++; if (bus.flush_cnt !== 4'd1 || bus.stall_cnt !== 4'd2) begin errors++; $display("FAIL br_cnt: got f=%0d s=%0d expected 1/2", bus.flush_cnt, bus.stall_cnt); end
    bus.branch_taken = 1'b0; bus.ex_mem_read = 1'b0;
    step();
    checks++; if (bus.instr_out !== mem[16] || bus.currentPC_out !== 32'h40 || bus.valid_out !== 1'b1) begin errors++; $display("FAIL br_target_fetch: got ins=%h cur=%h v=%b expected %h/40/1", bus.instr_out, bus.currentPC_out, bus.valid_out, mem[16]); end
  endtask

  task automatic test_mem_wait();
    bus.mem_wait = 1'b1;
    bus.branch_taken = 1'b1; bus.branch_target = 32'h100;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (bus.imem_addr !== 32'h44 || bus.currentPC_out !== 32'h40 || bus.instr_out !== mem[16] || bus.valid_out !== 1'b1) begin errors++; $display("FAIL wait_hold[%0d]: got pc=%h cur=%h ins=%h v=%b", k, bus.imem_addr, bus.currentPC_out, bus.instr_out, bus.valid_out); end
      checks++; if (bus.id_ex_bubble !== 1'b1 || bus.flush_cnt !== 4'd1) begin errors++; $display("FAIL wait_out[%0d]: got b=%b f=%0d expected 1/1", k, bus.id_ex_bubble, bus.flush_cnt); end
    end
    bus.mem_wait = 1'b0; bus.branch_taken = 1'b0;
    step();
    checks++; if (bus.instr_out !== mem[17] || bus.currentPC_out !== 32'h44) begin errors++; $display("FAIL wait_resume0: got ins=%h cur=%h expected %h/44", bus.instr_out, bus.currentPC_out, mem[17]); end
    step();
    checks++; if (bus.instr_out !== mem[18] || bus.currentPC_out !== 32'h48) begin errors++; $display("FAIL wait_resume1: got ins=%h cur=%h expected %h/48", bus.instr_out, bus.currentPC_out, mem[18]); end
  endtask

  task automatic test_pc_wrap();
    bus.branch_taken = 1'b1; bus.branch_target = 32'hFFFF_FFFC;
    step();
    checks++; if (bus.imem_addr !== 32'hFFFF_FFFC || bus.flush_cnt !== 4'd2) begin errors++; $display("FAIL wrap_redirect: got pc=%h f=%0d expected fffffffc/2", bus.imem_addr, bus.flush_cnt); end
    bus.branch_taken = 1'b0;
    step();
    checks++; if (bus.currentPC_out !== 32'hFFFF_FFFC || bus.nextPC_out !== 32'h0 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_pc: got cur=%h nxt=%h pc=%h expected fffffffc/0/0", bus.currentPC_out, bus.nextPC_out, bus.imem_addr); end
    checks++; if (bus.instr_out !== mem[63]) begin errors++; $display("FAIL wrap_instr: got %h expected %h", bus.instr_out, mem[63]); end
    step();
    checks++; if (bus.currentPC_out !== 32'h0 || bus.instr_out !== mem[0] || bus.imem_addr !== 32'h4) begin errors++; $display("FAIL wrap_next: got cur=%h ins=%h pc=%h", bus.currentPC_out, bus.instr_out, bus.imem_addr); end
  endtask

  task automatic test_saturate_and_reset();
    mem[1] = add_hz;
    step();  // IF/ID = add $3,$5,$2 at 0x4
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd5;
    repeat (12) step();
    checks++; if (bus.stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_pre: got %0d expected 14", bus.stall_cnt); end
    repeat (8) step();
    checks++; if (bus.stall_cnt !== 4'd15 || bus.imem_addr !== 32'h8) begin errors++; $display("FAIL sat_hold: got cnt=%0d pc=%h expected 15/8", bus.stall_cnt, bus.imem_addr); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.imem_addr !== 32'h0 || bus.instr_out !== 32'h0 || bus.valid_out !== 1'b0) begin errors++; $display("FAIL async_rst: got pc=%h ins=%h v=%b expected 0/0/0", bus.imem_addr, bus.instr_out, bus.valid_out); end
    checks++; if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0 || bus.currentPC_out !== 32'h0) begin errors++; $display("FAIL async_rst_cnt: got s=%0d f=%0d cur=%h expected 0/0/0", bus.stall_cnt, bus.flush_cnt, bus.currentPC_out); end
    #2;
    rst_n = 1'b1; bus.ex_mem_read = 1'b0;
    step();
    checks++; if (bus.instr_out !== mem[0] || bus.currentPC_out !== 32'h0 || bus.valid_out !== 1'b1 || bus.imem_addr !== 32'h4) begin errors++; $display("FAIL restart: got ins=%h cur=%h v=%b pc=%h", bus.instr_out, bus.currentPC_out, bus.valid_out, bus.imem_addr); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    add_hz   = {6'd0, 5'd5, 5'd2, 5'd3, 5'd0, 6'h20};
    add_r0   = {6'd0, 5'd0, 5'd0, 5'd3, 5'd0, 6'h20};
    sw_rt5   = {6'd43, 5'd1, 5'd5, 16'd0};
    addi_rt5 = {6'd8, 5'd1, 5'd5, 16'd1};
    for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 | 32'(i);
    mem[4] = add_hz;
    mem[5] = add_r0;
    mem[6] = sw_rt5;
    mem[7] = addi_rt5;
    mem[8] = add_hz;
    rst_n = 1'b0;
    bus.mem_wait      = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.ex_mem_read   = 1'b0;
    bus.ex_rt         = 5'd0;

    test_reset();
    test_fetch();
    test_load_use();
    test_branch_flush();
    test_mem_wait();
    test_pc_wrap();
    test_saturate_and_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
